// File: rtl/vtiming_pkg.sv
// ---------------------------------------------------------------------------
// vtiming_pkg
// Shared constants for the vertical timing controller: field widths, the
// reset-default 640x480@60 vertical timing and the configuration validity
// predicate used when a new timing set is offered.
// ---------------------------------------------------------------------------
package vtiming_pkg;

  localparam int VT_CNT_W   = 12;
  localparam int VT_CH_W    = 5;
  localparam int VT_ROW_W   = 7;
  localparam int VT_FRAME_W = 8;

  localparam int VT_DEF_VIS  = 480;
  localparam int VT_DEF_PB   = 490;
  localparam int VT_DEF_PE   = 492;
  localparam int VT_DEF_LAST = 524;
  localparam int VT_DEF_CH   = 16;

  // A timing set is usable only if the regions are ordered
  // visible <= sync begin < sync end <= last line and rows are non-empty.
  function automatic logic vt_cfg_ok(input int unsigned vis, input int unsigned pb,
                                     input int unsigned pe, input int unsigned last,
                                     input int unsigned ch);
    return (vis <= pb) && (pb < pe) && (pe <= last) && (ch != 0);
  endfunction

endpackage

// File: rtl/vtiming_ctrl_if.sv
// ---------------------------------------------------------------------------
// vtiming_ctrl_if
// Configuration handshake bundle for vtiming_ctrl.
//   cfgValid / cfgReady : valid/ready transfer of one timing set
//   cfgVis..cfgLast     : proposed vertical timing (CNT_W each)
//   cfgCh               : proposed character height (CH_W)
//   cfgSyncNeg          : 1 = active-low vertical sync
//   cfgError            : one-cycle pulse, offered set rejected
// master = configuration source, slave = timing controller.
// ---------------------------------------------------------------------------
interface vtiming_ctrl_if #(
  parameter int CNT_W = 12,
  parameter int CH_W  = 5
) ();
  logic             cfgValid;
  logic             cfgReady;
  logic [CNT_W-1:0] cfgVis;
  logic [CNT_W-1:0] cfgPB;
  logic [CNT_W-1:0] cfgPE;
  logic [CNT_W-1:0] cfgLast;
  logic [CH_W-1:0]  cfgCh;
  logic             cfgSyncNeg;
  logic             cfgError;

  modport master (
    output cfgValid, cfgVis, cfgPB, cfgPE, cfgLast, cfgCh, cfgSyncNeg,
    input  cfgReady, cfgError
  );

  modport slave (
    input  cfgValid, cfgVis, cfgPB, cfgPE, cfgLast, cfgCh, cfgSyncNeg,
    output cfgReady, cfgError
  );
endinterface

// File: rtl/vtiming_cfg_shadow.sv
// ---------------------------------------------------------------------------
// vtiming_cfg_shadow
// Holds the active vertical timing set plus one staging slot. An offered set
// is validated on transfer; good sets are staged and marked pending, bad sets
// raise cfgError for one cycle. The pending set becomes active at the frame
// wrap so a frame never runs with mixed timing.
// Ports:
//   clk, nrst      : clock, synchronous active-low reset
//   wrap           : last line of the frame is ending this cycle
//   cfg            : configuration handshake (slave side)
//   act_*          : currently active timing set
// ---------------------------------------------------------------------------
module vtiming_cfg_shadow
  import vtiming_pkg::*;
#(
  parameter int CNT_W    = VT_CNT_W,
  parameter int CH_W     = VT_CH_W,
  parameter int DEF_VIS  = VT_DEF_VIS,
  parameter int DEF_PB   = VT_DEF_PB,
  parameter int DEF_PE   = VT_DEF_PE,
  parameter int DEF_LAST = VT_DEF_LAST,
  parameter int DEF_CH   = VT_DEF_CH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wrap,
  vtiming_ctrl_if.slave    cfg,
  output logic [CNT_W-1:0] act_vis,
  output logic [CNT_W-1:0] act_pb,
  output logic [CNT_W-1:0] act_pe,
  output logic [CNT_W-1:0] act_last,
  output logic [CH_W-1:0]  act_ch,
  output logic             act_sync_neg
);

  typedef struct packed {
    logic [CNT_W-1:0] vis;
    logic [CNT_W-1:0] pb;
    logic [CNT_W-1:0] pe;
    logic [CNT_W-1:0] last;
    logic [CH_W-1:0]  ch;
    logic             sync_neg;
  } cfg_t;

  cfg_t stage_q, stage_d, act_q, act_d, offer;
  logic pending_q, pending_d;
  logic err_q, err_d;
  logic xfer, offer_ok;

  always_comb begin
    offer.vis      = cfg.cfgVis;
    offer.pb       = cfg.cfgPB;
    offer.pe       = cfg.cfgPE;
    offer.last     = cfg.cfgLast;
    offer.ch       = cfg.cfgCh;
    offer.sync_neg = cfg.cfgSyncNeg;
  end

  assign xfer     = cfg.cfgValid & ~pending_q;
  assign offer_ok = vt_cfg_ok(32'(offer.vis), 32'(offer.pb), 32'(offer.pe),
                              32'(offer.last), 32'(offer.ch));

  // Apply and accept are mutually exclusive: apply needs pending set, accept
  // needs it clear. A transfer in the wrap cycle therefore only stages and
  // waits for the following wrap.
  always_comb begin
    stage_d   = stage_q;
    act_d     = act_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    if (wrap && pending_q) begin
      act_d     = stage_q;
      pending_d = 1'b0;
    end
    if (xfer) begin
      if (offer_ok) begin
        stage_d   = offer;
        pending_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      act_q.vis      <= CNT_W'(DEF_VIS);
      act_q.pb       <= CNT_W'(DEF_PB);
      act_q.pe       <= CNT_W'(DEF_PE);
      act_q.last     <= CNT_W'(DEF_LAST);
      act_q.ch       <= CH_W'(DEF_CH);
      act_q.sync_neg <= 1'b0;
      stage_q        <= '0;
      pending_q      <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      act_q     <= act_d;
      stage_q   <= stage_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign cfg.cfgReady = ~pending_q;
  assign cfg.cfgError = err_q;

  assign act_vis      = act_q.vis;
  assign act_pb       = act_q.pb;
  assign act_pe       = act_q.pe;
  assign act_last     = act_q.last;
  assign act_ch       = act_q.ch;
  assign act_sync_neg = act_q.sync_neg;

endmodule

// File: rtl/vtiming_ctrl.sv
// ---------------------------------------------------------------------------
// vtiming_ctrl
// Runtime-programmable vertical timing controller. Advances one line per
// lineEnd pulse and decodes visible region, vertical sync, frame start,
// character row position and a frame counter. New timing arrives through the
// cfg handshake and is switched in at a frame boundary.
// Ports:
//   clk, nrst   : clock, synchronous active-low reset
//   lineEnd     : one-cycle end-of-scanline pulse (may repeat every cycle)
//   cfg         : configuration handshake (slave side)
//   vCount      : current line
//   vVisible    : current line is in the visible region
//   vSync       : vertical sync with selected polarity
//   frameStart  : one-cycle pulse in the first cycle vCount reads 0
//   rowLine     : line within the current character row
//   charRow     : character row index
//   frameCount  : completed-frame counter (wraps)
// ---------------------------------------------------------------------------
module vtiming_ctrl
  import vtiming_pkg::*;
#(
  parameter int CNT_W    = VT_CNT_W,
  parameter int CH_W     = VT_CH_W,
  parameter int ROW_W    = VT_ROW_W,
  parameter int FRAME_W  = VT_FRAME_W,
  parameter int DEF_VIS  = VT_DEF_VIS,
  parameter int DEF_PB   = VT_DEF_PB,
  parameter int DEF_PE   = VT_DEF_PE,
  parameter int DEF_LAST = VT_DEF_LAST,
  parameter int DEF_CH   = VT_DEF_CH,
  parameter int INIT_VAL = DEF_LAST
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               lineEnd,
  vtiming_ctrl_if.slave      cfg,
  output logic [CNT_W-1:0]   vCount,
  output logic               vVisible,
  output logic               vSync,
  output logic               frameStart,
  output logic [CH_W-1:0]    rowLine,
  output logic [ROW_W-1:0]   charRow,
  output logic [FRAME_W-1:0] frameCount
);

  logic [CNT_W-1:0] act_vis, act_pb, act_pe, act_last;
  logic [CH_W-1:0]  act_ch;
  logic             act_sync_neg;

  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic               sync_raw_q, sync_raw_d;
  logic               frame_start_q, frame_start_d;
  logic [CH_W-1:0]    row_line_q, row_line_d;
  logic [ROW_W-1:0]   char_row_q, char_row_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             wrap;
  logic [CNT_W-1:0] next_line;
  logic             next_vis;

  vtiming_cfg_shadow #(
    .CNT_W    (CNT_W),
    .CH_W     (CH_W),
    .DEF_VIS  (DEF_VIS),
    .DEF_PB   (DEF_PB),
    .DEF_PE   (DEF_PE),
    .DEF_LAST (DEF_LAST),
    .DEF_CH   (DEF_CH)
  ) u_shadow (
    .clk          (clk),
    .nrst         (nrst),
    .wrap         (wrap),
    .cfg          (cfg),
    .act_vis      (act_vis),
    .act_pb       (act_pb),
    .act_pe       (act_pe),
    .act_last     (act_last),
    .act_ch       (act_ch),
    .act_sync_neg (act_sync_neg)
  );

  assign wrap      = lineEnd & (vcount_q == act_last);
  assign next_line = wrap ? '0 : vcount_q + 1'b1;
  assign next_vis  = next_line < act_vis;

  always_comb begin
    vcount_d      = vcount_q;
    sync_raw_d    = sync_raw_q;
    row_line_d    = row_line_q;
    char_row_d    = char_row_q;
    frame_cnt_d   = frame_cnt_q;
    frame_start_d = wrap;
    if (lineEnd) begin
      vcount_d = next_line;
      // Decoding on the line being entered keeps sync aligned to lines pb..pe-1
      // with the flop updating together with vCount.
      if (next_line == act_pb)      sync_raw_d = 1'b1;
      else if (next_line == act_pe) sync_raw_d = 1'b0;
      if (wrap) begin
        row_line_d  = '0;
        char_row_d  = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end else if (next_vis) begin
        if (row_line_q == act_ch - 1'b1) begin
          row_line_d = '0;
          char_row_d = char_row_q + 1'b1;
        end else begin
          row_line_d = row_line_q + 1'b1;
        end
      end
      // Blanking lines: row tracking holds until the wrap clears it.
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      vcount_q      <= CNT_W'(INIT_VAL);
      sync_raw_q    <= 1'b0;
      frame_start_q <= 1'b0;
      row_line_q    <= '0;
      char_row_q    <= '0;
      frame_cnt_q   <= '0;
    end else begin
      vcount_q      <= vcount_d;
      sync_raw_q    <= sync_raw_d;
      frame_start_q <= frame_start_d;
      row_line_q    <= row_line_d;
      char_row_q    <= char_row_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vCount     = vcount_q;
  assign vVisible   = vcount_q < act_vis;
  assign vSync      = sync_raw_q ^ act_sync_neg;
  assign frameStart = frame_start_q;
  assign rowLine    = row_line_q;
  assign charRow    = char_row_q;
  assign frameCount = frame_cnt_q;

endmodule

// File: tb/tb_vtiming_ctrl.sv
module tb_vtiming_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        lineEnd;
  logic [11:0] vCount;
  logic        vVisible, vSync, frameStart;
  logic [4:0]  rowLine;
  logic [6:0]  charRow;
  logic [7:0]  frameCount;

  int n_chk  = 0;
  int n_fail = 0;

  vtiming_ctrl_if #(.CNT_W(12), .CH_W(5)) cfg_if ();

  vtiming_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .lineEnd    (lineEnd),
    .cfg        (cfg_if),
    .vCount     (vCount),
    .vVisible   (vVisible),
    .vSync      (vSync),
    .frameStart (frameStart),
    .rowLine    (rowLine),
    .charRow    (charRow),
    .frameCount (frameCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pulses;   // cumulative lineEnd pulses since reset
    int vcount;
    bit vis;
    bit sync;
    int row;
    int crow;
    int fc;
    bit fs;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs for one cycle; returns at the following negedge so outputs
  // reflect that edge.
  task automatic tick(input bit le, input bit cv);
    lineEnd         = le;
    cfg_if.cfgValid = cv;
    @(posedge clk);
    @(negedge clk);
    lineEnd         = 1'b0;
    cfg_if.cfgValid = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  task automatic set_cfg(input int vis, input int pb, input int pe,
                         input int last, input int ch, input bit neg);
    cfg_if.cfgVis     = 12'(vis);
    cfg_if.cfgPB      = 12'(pb);
    cfg_if.cfgPE      = 12'(pe);
    cfg_if.cfgLast    = 12'(last);
    cfg_if.cfgCh      = 5'(ch);
    cfg_if.cfgSyncNeg = neg;
  endtask

  // From line 0, run back-to-back lineEnd until the next frameStart;
  // reports line count and visible / sync-high lines of that frame.
  task automatic measure(output int len, output int vis, output int syn);
    bit done = 1'b0;
    len = 0; vis = 0; syn = 0;
    while (!done) begin
      if (vVisible) vis++;
      if (vSync)    syn++;
      tick(1'b1, 1'b0);
      len++;
      if (frameStart || len >= 4000) done = 1'b1;
    end
    if (!frameStart) chk("frame_timeout", 0, 1);
  endtask

  int len, vis, syn;

  initial begin
    nrst = 1'b0; lineEnd = 1'b0; cfg_if.cfgValid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);

    //                pulses line vis sync row crow fc fs
    tbl[0]  = '{    1,   0, 1, 0,  0,  0, 1, 1};
    tbl[1]  = '{   16,  15, 1, 0, 15,  0, 1, 0};
    tbl[2]  = '{   17,  16, 1, 0,  0,  1, 1, 0};
    tbl[3]  = '{  480, 479, 1, 0, 15, 29, 1, 0};
    tbl[4]  = '{  481, 480, 0, 0, 15, 29, 1, 0};
    tbl[5]  = '{  490, 489, 0, 0, 15, 29, 1, 0};
    tbl[6]  = '{  491, 490, 0, 1, 15, 29, 1, 0};
    tbl[7]  = '{  492, 491, 0, 1, 15, 29, 1, 0};
    tbl[8]  = '{  493, 492, 0, 0, 15, 29, 1, 0};
    tbl[9]  = '{  525, 524, 0, 0, 15, 29, 1, 0};
    tbl[10] = '{  526,   0, 1, 0,  0,  0, 2, 1};

    @(negedge clk);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    nrst = 1'b1;

    // Reset state
    chk("rst_vcount", vCount, 524);
    chk("rst_vis", vVisible, 0);
    chk("rst_sync", vSync, 0);
    chk("rst_fs", frameStart, 0);
    chk("rst_row", rowLine, 0);
    chk("rst_crow", charRow, 0);
    chk("rst_fc", frameCount, 0);
    chk("rst_ready", cfg_if.cfgReady, 1);
    chk("rst_err", cfg_if.cfgError, 0);

    // Default frame, table-driven
    begin
      int p = 0;
      foreach (tbl[k]) begin
        while (p < tbl[k].pulses) begin tick(1'b1, 1'b0); p++; end
        chk($sformatf("t%0d_vcount", k), vCount, tbl[k].vcount);
        chk($sformatf("t%0d_vis", k), vVisible, tbl[k].vis);
        chk($sformatf("t%0d_sync", k), vSync, tbl[k].sync);
        chk($sformatf("t%0d_row", k), rowLine, tbl[k].row);
        chk($sformatf("t%0d_crow", k), charRow, tbl[k].crow);
        chk($sformatf("t%0d_fc", k), frameCount, tbl[k].fc);
        chk($sformatf("t%0d_fs", k), frameStart, tbl[k].fs);
      end
    end
    measure(len, vis, syn);
    chk("def_len", len, 525);
    chk("def_vis", vis, 480);
    chk("def_sync", syn, 2);

    // Mid-frame load of a 628-line timing
    pulses(100);
    set_cfg(600, 601, 605, 627, 8, 1'b0);
    tick(1'b0, 1'b1);
    chk("ld_ready_low", cfg_if.cfgReady, 0);
    chk("ld_err", cfg_if.cfgError, 0);
    pulses(424);
    chk("ld_old_last", vCount, 524);
    chk("ld_ready_still_low", cfg_if.cfgReady, 0);
    tick(1'b1, 1'b0);
    chk("ld_wrap_vcount", vCount, 0);
    chk("ld_wrap_fs", frameStart, 1);
    chk("ld_ready_back", cfg_if.cfgReady, 1);
    measure(len, vis, syn);
    chk("ld_len", len, 628);
    chk("ld_vis", vis, 600);
    chk("ld_sync", syn, 4);
    pulses(9);
    chk("ld_ch8_row", rowLine, 1);
    chk("ld_ch8_crow", charRow, 1);
    pulses(619);
    chk("ld_back_at_0", vCount, 0);

    // Reset mid-frame with a pending set
    pulses(50);
    set_cfg(100, 110, 112, 199, 4, 1'b1);
    tick(1'b0, 1'b1);
    chk("rp_pending", cfg_if.cfgReady, 0);
    nrst = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    nrst = 1'b1;
    chk("rp_vcount", vCount, 524);
    chk("rp_ready", cfg_if.cfgReady, 1);
    chk("rp_row", rowLine, 0);
    chk("rp_crow", charRow, 0);
    chk("rp_fc", frameCount, 0);
    chk("rp_sync", vSync, 0);
    chk("rp_fs", frameStart, 0);
    tick(1'b1, 1'b0);
    chk("rp_fs_first", frameStart, 1);
    measure(len, vis, syn);
    chk("rp_len1", len, 525);
    chk("rp_vis1", vis, 480);
    measure(len, vis, syn);
    chk("rp_len2", len, 525);
    chk("rp_sync2", syn, 2);

    // Rejected sets
    set_cfg(480, 500, 500, 524, 16, 1'b0);
    tick(1'b0, 1'b1);
    chk("bad_err", cfg_if.cfgError, 1);
    chk("bad_ready", cfg_if.cfgReady, 1);
    tick(1'b0, 1'b0);
    chk("bad_err_once", cfg_if.cfgError, 0);
    set_cfg(480, 490, 492, 524, 0, 1'b0);
    tick(1'b0, 1'b1);
    chk("bad_ch0_err", cfg_if.cfgError, 1);
    chk("bad_ch0_ready", cfg_if.cfgReady, 1);
    measure(len, vis, syn);
    chk("bad_len", len, 525);
    chk("bad_vis", vis, 480);

    // Offer in the exact wrap cycle: applies one frame later
    pulses(524);
    chk("wc_at_last", vCount, 524);
    set_cfg(600, 601, 605, 627, 8, 1'b0);
    tick(1'b1, 1'b1);
    chk("wc_vcount", vCount, 0);
    chk("wc_ready", cfg_if.cfgReady, 0);
    measure(len, vis, syn);
    chk("wc_len_old", len, 525);
    chk("wc_ready_back", cfg_if.cfgReady, 1);
    measure(len, vis, syn);
    chk("wc_len_new", len, 628);

    // Active-low sync load
    set_cfg(480, 490, 492, 524, 16, 1'b1);
    tick(1'b0, 1'b1);
    chk("neg_ready", cfg_if.cfgReady, 0);
    measure(len, vis, syn);
    chk("neg_len_old", len, 628);
    chk("neg_sync_old", syn, 4);
    chk("neg_line0_high", vSync, 1);
    measure(len, vis, syn);
    chk("neg_len", len, 525);
    chk("neg_sync_high", syn, 523);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vtiming_ctrl.md
# vtiming_ctrl

Parametrised, runtime-programmable vertical timing controller for the FPGA display controller, replacing the fixed-constant vertical counter. It advances once per scanline on the horizontal end-of-line pulse. It produces the line count, visible-region flag, polarity-selectable vertical sync, frame-start pulse, character-row tracking and a frame counter. New timing is loaded through a valid/ready handshake and takes effect only at a frame boundary.

## Interface
- CNT_W, 12: width of line counter and timing fields
- CH_W, 5: width of character-height field and rowLine
- ROW_W, 7: width of charRow
- FRAME_W, 8: width of frameCount
- DEF_VIS, 480: reset-default visible line count
- DEF_PB, 490: reset-default sync begin line
- DEF_PE, 492: reset-default sync end line (exclusive)
- DEF_LAST, 524: reset-default last line index (525 lines)
- DEF_CH, 16: reset-default character height in lines
- INIT_VAL, DEF_LAST: count value after reset

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- lineEnd  in  1  one-cycle pulse at end of each scanline
- cfgValid  in  1  new configuration offered
- cfgReady  out  1  staging slot free
- cfgVis, cfgPB, cfgPE, cfgLast  in  CNT_W each  proposed timing
- cfgCh  in  CH_W  proposed character height, 1..2^CH_W-1
- cfgSyncNeg  in  1  1 = active-low sync
- cfgError  out  1  one-cycle pulse: offered configuration rejected
- vCount  out  CNT_W  current line
- vVisible  out  1  vCount < active visible count
- vSync  out  1  sync, polarity applied
- frameStart  out  1  one-cycle pulse when vCount becomes 0
- rowLine  out  CH_W  line within current character row
- charRow  out  ROW_W  character row index
- frameCount  out  FRAME_W  completed-frame counter, wraps

## Operation
- Active config register set = {vis, pb, pe, last, ch, syncNeg}. Single staging set plus a pending flag.
- Reset: active set = defaults, syncNeg = 0, and pending = 0. Reset values: cfgReady = 1, vCount = INIT_VAL, raw sync = 0, rowLine = 0, charRow = 0, frameCount = 0, frameStart = 0, cfgError = 0. Reset mid-frame discards any pending config.
- Handshake: a transfer occurs when cfgValid & cfgReady. cfgReady = ~pending.
- Validation on transfer: require vis ≤ pb < pe ≤ last and ch ≠ 0.
  - Pass: copy into staging and set pending.
  - Fail: pulse cfgError the next cycle; staging and pending are unchanged.
- Count: on lineEnd, vCount = 0 if vCount == last, else vCount+1. Without lineEnd, vCount holds.
- Wrap (lineEnd & vCount == last): if pending, load staging into active and clear pending. frameCount+1. rowLine and charRow clear to 0.
- Raw sync: set on lineEnd & vCount == pb−1 (sync spans lines pb..pe−1); cleared on lineEnd & vCount == pe−1. vSync = raw ^ syncNeg.
- vVisible is combinational from vCount and the active vis value.
- Character rows: on lineEnd with the next line visible, rowLine == ch−1 causes rowLine = 0 and charRow+1 (charRow wraps at 2^ROW_W); otherwise rowLine+1. With the next line not visible, rowLine and charRow hold until the wrap clear.

## Timing
- All outputs except vVisible and vSync polarity are registered.
- vCount, rowLine, charRow and raw sync update in the cycle after lineEnd.
- frameStart is asserted in the same cycle vCount first reads 0.
- A config accepted at cycle t is applied at the first wrap strictly after t. A transfer in the wrap cycle itself waits for the following frame.
- cfgReady falls the cycle after acceptance and rises the cycle after the applying wrap.
- The new syncNeg takes effect together with the rest of the set, in the cycle vCount reads 0.
- Back-to-back lineEnd on consecutive cycles must be supported.

## Structure
- Shared package/header vtiming_pkg: default timing constants, field widths, and the validation predicate as a function.
- Sub-module vtiming_cfg_shadow: staging registers, pending flag, validation, cfgReady/cfgError, and the apply-on-wrap load. The top level holds the counters and decode.

## Test plan
- Reset with defaults, 525 lineEnd pulses: vCount sequence 524,0..524. One frameStart. vVisible high for exactly 480 lines. Raw sync high for lines 490–491. frameCount = 1.
- charRow tracking with DEF_CH = 16 over one frame: rowLine cycles 0..15. charRow reaches 29 at line 479, then holds until the wrap clears it.
- Mid-frame load of vis=600, pb=601, pe=605, last=627, ch=8: cfgReady drops. The current frame keeps 525 lines. The next frame has 628 lines and 600 visible lines. cfgReady returns.
- Invalid load (pb = pe = 500): cfgError pulses once. cfgReady stays 1. Timing is unchanged.
- cfgValid asserted in the exact wrap cycle: the config is applied at the following wrap, not the current one.
- Reset asserted mid-frame with a pending config: all outputs at reset values and defaults restored; the pending config never applies. Separately, a syncNeg=1 load leaves vSync high outside lines 490–491 once applied.
